// File: rtl/nn_fixed_pkg.sv
// -----------------------------------------------------------------------------
// nn_fixed_pkg
//   Fixed-point constants and shared types for the neuron datapath. The
//   multiply-accumulate front end and the sigmoid stage both use these, so the
//   Q8.24 format and the saturation limits are defined in one place.
//
//   Contents:
//     DATA_W, FRAC_BITS, ACC_W, MAX_TERMS : default datapath geometry
//     Q_ONE                               : 1.0 in Q8.24
//     SAT_MAX / SAT_MIN                   : Q8.24 clip limits
//     mac_state_e                         : MAC controller states
// -----------------------------------------------------------------------------
package nn_fixed_pkg;

    localparam int DATA_W    = 32;
    localparam int FRAC_BITS = 24;
    localparam int ACC_W     = 48;
    localparam int MAX_TERMS = 256;

    localparam logic [DATA_W-1:0] Q_ONE   = 32'h0100_0000;
    localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // waiting for the first beat of a neuron
        ST_ACC   = 2'd1,  // streaming terms into the accumulator
        ST_FLUSH = 2'd2,  // folding in the last product and clipping
        ST_HOLD  = 2'd3   // result presented, waiting for out_ready
    } mac_state_e;

endpackage : nn_fixed_pkg

// File: rtl/fx_saturate.sv
// -----------------------------------------------------------------------------
// fx_saturate
//   Clips a wide signed value to a narrower signed range. Values above the
//   largest OUT_W-bit signed number become that maximum, values below the
//   smallest become that minimum; anything in range passes through as its low
//   OUT_W bits. clipped_o flags that a limit was applied.
//
//   Ports:
//     sum_i      in   IN_W   signed input value
//     data_o     out  OUT_W  signed clipped value
//     clipped_o  out  1      data_o differs from sum_i
// -----------------------------------------------------------------------------
module fx_saturate #(
    parameter int IN_W  = 48,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  sum_i,
    output logic [OUT_W-1:0] data_o,
    output logic             clipped_o
);

    // Output limits sign-extended to the input width so the compare happens
    // at full precision.
    localparam logic [IN_W-1:0] HI_EXT = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [IN_W-1:0] LO_EXT = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic over;
    logic under;

    assign over  = $signed(sum_i) > $signed(HI_EXT);
    assign under = $signed(sum_i) < $signed(LO_EXT);

    always_comb begin
        // NOTE: every output gets a value on every path, so no latch is inferred.
        data_o    = sum_i[OUT_W-1:0];
        clipped_o = 1'b0;
        if (over) begin
            data_o    = HI_EXT[OUT_W-1:0];
            clipped_o = 1'b1;
        end else if (under) begin
            data_o    = LO_EXT[OUT_W-1:0];
            clipped_o = 1'b1;
        end
    end

endmodule : fx_saturate

// File: rtl/neuron_mac.sv
// -----------------------------------------------------------------------------
// neuron_mac
//   Serial multiply-accumulate front end of a neuron. Streams (activation,
//   weight) beats, forms bias + sum(x*w) in signed Q8.24 using a Q24.24
//   accumulator, saturates to DATA_W bits and presents one pre-activation value
//   per neuron to the sigmoid stage.
//
//   Ports:
//     clk        in   1       clock, rising edge
//     rst        in   1       synchronous active-high reset
//     bias       in   DATA_W  neuron bias, taken on the first beat only
//     in_valid   in   1       in_x/in_w/in_last valid
//     in_ready   out  1       a beat is accepted this cycle if in_valid
//     in_x       in   DATA_W  activation, Q8.24
//     in_w       in   DATA_W  weight, Q8.24
//     in_last    in   1       final term of this neuron
//     out_valid  out  1       out_data valid, held until out_ready
//     out_ready  in   1       downstream accepts out_data
//     out_data   out  DATA_W  saturated pre-activation, Q8.24
//     out_sat    out  1       out_data was clipped
//     out_ovr    out  1       MAX_TERMS reached without in_last
// -----------------------------------------------------------------------------
module neuron_mac
    import nn_fixed_pkg::*;
#(
    parameter int DATA_W    = nn_fixed_pkg::DATA_W,
    parameter int FRAC_BITS = nn_fixed_pkg::FRAC_BITS,
    parameter int ACC_W     = nn_fixed_pkg::ACC_W,
    parameter int MAX_TERMS = nn_fixed_pkg::MAX_TERMS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_w,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat,
    output logic              out_ovr
);

    localparam int              CNT_W = $clog2(MAX_TERMS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TERMS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mac_state_e        state_q,     state_d;
    logic [ACC_W-1:0]  acc_q,       acc_d;
    logic [ACC_W-1:0]  prod_q,      prod_d;
    logic              prod_vld_q,  prod_vld_d;   // prod_q not yet added to acc_q
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              ovr_q,       ovr_d;        // term limit hit in this neuron
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_sat_q,   out_sat_d;
    logic              out_ovr_q,   out_ovr_d;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic                       beat;
    logic signed [2*DATA_W-1:0] prod_full;
    logic [ACC_W-1:0]           prod_ext;
    logic [ACC_W-1:0]           bias_ext;
    logic [ACC_W-1:0]           sum;
    logic [DATA_W-1:0]          sat_data;
    logic                       sat_clip;
    logic [CNT_W-1:0]           cnt_inc;

    // Ready depends on rst directly so nothing is accepted while reset is held,
    // whatever state the register happens to be in.
    assign in_ready = !rst && (state_q == ST_IDLE || state_q == ST_ACC);
    assign beat     = in_valid && in_ready;

    // Full-width signed product; the arithmetic shift drops the extra fraction
    // bits rounding toward -inf. The remaining value fits in ACC_W bits, so
    // keeping the low ACC_W bits is a correct sign extension.
    assign prod_full = $signed(in_x) * $signed(in_w);
    assign prod_ext  = ACC_W'(prod_full >>> FRAC_BITS);
    assign bias_ext  = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
    assign cnt_inc   = cnt_q + CNT_ONE;

    assign sum = acc_q + (prod_vld_q ? prod_q : '0);

    fx_saturate #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W)
    ) u_sat (
        .sum_i     (sum),
        .data_o    (sat_data),
        .clipped_o (sat_clip)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        prod_vld_d  = prod_vld_q;
        cnt_d       = cnt_q;
        ovr_d       = ovr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_ovr_d   = out_ovr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    acc_d      = bias_ext;
                    prod_d     = prod_ext;
                    prod_vld_d = 1'b1;
                    cnt_d      = CNT_ONE;
                    ovr_d      = !in_last && (CNT_ONE == CNT_MAX);
                    state_d    = (in_last || CNT_ONE == CNT_MAX) ? ST_FLUSH : ST_ACC;
                end
            end

            ST_ACC: begin
                // The previous product is folded in every cycle; a new beat
                // replaces it in the same cycle, keeping one beat per clock.
                if (prod_vld_q) begin
                    acc_d = acc_q + prod_q;
                end
                prod_vld_d = 1'b0;
                if (beat) begin
                    prod_d     = prod_ext;
                    prod_vld_d = 1'b1;
                    cnt_d      = cnt_inc;
                    if (in_last) begin
                        state_d = ST_FLUSH;
                    end else if (cnt_inc == CNT_MAX) begin
                        ovr_d   = 1'b1;
                        state_d = ST_FLUSH;
                    end
                end
            end

            ST_FLUSH: begin
                out_data_d  = sat_data;
                out_sat_d   = sat_clip;
                out_ovr_d   = ovr_q;
                out_valid_d = 1'b1;
                prod_vld_d  = 1'b0;
                state_d     = ST_HOLD;
            end

            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_sat_d   = 1'b0;
                    out_ovr_d   = 1'b0;
                    ovr_d       = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            cnt_q       <= '0;
            ovr_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            cnt_q       <= cnt_d;
            ovr_q       <= ovr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_ovr_q   <= out_ovr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_ovr   = out_ovr_q;

endmodule : neuron_mac

// File: tb/tb_neuron_mac.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac
//   Directed bench for neuron_mac with a 4-term limit. Expected values are
//   hand-computed Q8.24 results.
// -----------------------------------------------------------------------------
module tb_neuron_mac;
    import nn_fixed_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_w;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic        out_ovr;

    int checks = 0;
    int errors = 0;

    neuron_mac #(
        .DATA_W    (32),
        .FRAC_BITS (24),
        .ACC_W     (48),
        .MAX_TERMS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_ovr   (out_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] w, input logic last);
        in_valid = v;
        in_x     = x;
        in_w     = w;
        in_last  = last;
    endtask

    // Bounded wait for out_valid, then check the whole result.
    task automatic expect_out(input string tag, input logic [31:0] data,
                              input logic sat, input logic ovr);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"},  out_data,           data);
        check({tag, "_sat"},   {31'd0, out_sat},   {31'd0, sat});
        check({tag, "_ovr"},   {31'd0, out_ovr},   {31'd0, ovr});
    endtask

    task automatic accept_out(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_released"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready"},    {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        bias      = '0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        #1;

        // ---------------- reset ----------------
        step();
        step();
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  out_data,           32'd0);
        check("rst_out_sat",   {31'd0, out_sat},   32'd0);
        check("rst_out_ovr",   {31'd0, out_ovr},   32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // ---------------- 1 term, latency: 2.0*3.0 + 0.5 = 6.5 ----------------
        bias = 32'h0080_0000;
        drive(1'b1, 32'h0200_0000, 32'h0300_0000, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        check("t1_lat_valid_T1", {31'd0, out_valid}, 32'd0);
        check("t1_flush_ready",  {31'd0, in_ready},  32'd0);
        step();
        check("t1_lat_valid_T2", {31'd0, out_valid}, 32'd1);
        expect_out("t1", 32'h0680_0000, 1'b0, 1'b0);
        accept_out("t1");

        // ---------------- 3 back-to-back: 1 - 1 + 1 = 1.0, bias change ignored ----------------
        bias = 32'h0000_0000;
        drive(1'b1, Q_ONE, Q_ONE, 1'b0);
        step();
        bias = 32'h0500_0000;
        check("t2_ready_b2", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 32'hFE00_0000, 32'h0080_0000, 1'b0);
        step();
        check("t2_ready_b3", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 32'h0040_0000, 32'h0400_0000, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        expect_out("t2", 32'h0100_0000, 1'b0, 1'b0);
        accept_out("t2");

        // ---------------- positive saturation: 16*16 = 256 ----------------
        bias = 32'h0000_0000;
        drive(1'b1, 32'h1000_0000, 32'h1000_0000, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        expect_out("sat_pos", 32'h7FFF_FFFF, 1'b1, 1'b0);
        accept_out("sat_pos");

        // ---------------- negative saturation: -16*16 = -256 ----------------
        drive(1'b1, 32'hF000_0000, 32'h1000_0000, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        expect_out("sat_neg", 32'h8000_0000, 1'b1, 1'b0);
        accept_out("sat_neg");
        check("sat_flag_cleared", {31'd0, out_sat}, 32'd0);

        // ---------------- truncation toward -inf: 2^-24 * -0.5 -> -2^-24 ----------------
        drive(1'b1, 32'h0000_0001, 32'hFF80_0000, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        expect_out("trunc", 32'hFFFF_FFFF, 1'b0, 1'b0);
        accept_out("trunc");

        // ---------------- term limit: 4 beats of 1.0*1.0, no in_last ----------------
        drive(1'b1, Q_ONE, Q_ONE, 1'b0);
        step();
        step();
        step();
        step();
        // 5th beat still offered; must be stalled.
        check("ovr_5th_stalled", {31'd0, in_ready}, 32'd0);
        step();
        check("ovr_hold_stalled", {31'd0, in_ready}, 32'd0);
        expect_out("ovr", 32'h0400_0000, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0);
        accept_out("ovr");
        check("ovr_flag_cleared", {31'd0, out_ovr}, 32'd0);

        // ---------------- backpressure: 1.5*2.0 + 0.25 = 3.25 ----------------
        bias = 32'h0040_0000;
        drive(1'b1, 32'h0180_0000, 32'h0200_0000, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        expect_out("bp", 32'h0340_0000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_data",  out_data,           32'h0340_0000);
            check("bp_hold_ready", {31'd0, in_ready},  32'd0);
        end
        accept_out("bp");
        bias = 32'h0000_0000;
        drive(1'b1, 32'hFF00_0000, 32'h0080_0000, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        expect_out("bp_next", 32'hFF80_0000, 1'b0, 1'b0);
        accept_out("bp_next");

        // ---------------- reset mid-neuron ----------------
        bias = 32'h0300_0000;
        drive(1'b1, Q_ONE, Q_ONE, 1'b0);
        step();
        step();
        drive(1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_idle_ready", {31'd0, in_ready}, 32'd1);
        bias = 32'h0000_0000;
        drive(1'b1, Q_ONE, Q_ONE, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        expect_out("after_rst", 32'h0100_0000, 1'b0, 1'b0);
        accept_out("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_neuron_mac
